// File: rtl/param_counter_pkg.sv
// Shared constants for the parameterised up/down counter and its prescaler.
package param_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Width of a counter that must hold 0..n-1; a 1-bit counter is kept even for n=1.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: raises tick on the enabled edge where the phase counter reaches PRESCALE-1.
module tick_gen
    import param_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = clog2_min1(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] psc_q;
    logic [CW-1:0] psc_d;

    always_comb begin
        psc_d = psc_q;
        tick  = 1'b0;
        if (clear) begin
            psc_d = '0;
        end else if (en) begin
            if (psc_q == LAST) begin
                psc_d = '0;
                tick  = 1'b1;
            end else begin
                psc_d = psc_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

endmodule

// File: rtl/param_counter.sv
// Prescaled up/down counter with wrap or saturate at the boundary, match compare,
// terminal-count pulse and sticky overflow flag.
module param_counter
    import param_counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               PRESCALE  = 1,
    parameter int               SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] match_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             match_comb,
    output logic             match_reg,
    output logic             tc,
    output logic             ovf
);

    localparam mode_e            MODE    = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic             tick;
    logic             at_boundary;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             match_reg_q;
    logic             match_reg_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;

    // A load restarts the prescale phase so the loaded value gets a full period.
    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clear (load),
        .tick  (tick)
    );

    assign match_comb = (count_q == match_val);

    always_comb begin
        count_d     = count_q;
        tc_d        = 1'b0;
        ovf_d       = ovf_q;
        match_reg_d = match_comb;
        at_boundary = (dir == DIR_UP) ? (count_q == CNT_MAX) : (count_q == '0);

        if (load) begin
            count_d = load_val;
        end else if (tick) begin
            if (at_boundary) begin
                tc_d = 1'b1;
                if (MODE == MODE_WRAP) begin
                    count_d = (dir == DIR_UP) ? '0 : CNT_MAX;
                end
            end else if (dir == DIR_DOWN) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end

        // A boundary event on the same edge as a clear must not be lost.
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (!load && tick && at_boundary) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q     <= RESET_VAL;
            match_reg_q <= 1'b0;
            tc_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            match_reg_q <= match_reg_d;
            tc_q        <= tc_d;
            ovf_q       <= ovf_d;
        end
    end

    assign count     = count_q;
    assign match_reg = match_reg_q;
    assign tc        = tc_q;
    assign ovf       = ovf_q;

endmodule
